// File: rtl/mod_veda_pkg.sv
// mod_veda_pkg
//   Shared definitions for the mod_veda register file family:
//   op encodings, FSM state type and default widths.
//   Used by mod_veda_rf (top) and mod_veda_rf_bank (storage).
//   Related build macro: MOD_VEDA_RF_SWAP_EN (enables SWAP in mod_veda_rf).
package mod_veda_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SWAP2 = 1'b1
  } state_t;

endpackage

// File: rtl/mod_veda_rf_bank.sv
// mod_veda_rf_bank
//   DEPTH x DATA_W storage array: two asynchronous read ports, one
//   synchronous write port, synchronous active-low clear.
//   With ZERO_REG = 1, entry 0 ignores writes and always reads 0.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   we, waddr, wdata          write port
//   raddr_a/b, rdata_a/b      asynchronous read ports
module mod_veda_rf_bank
  import mod_veda_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              zero_hit_w;

  assign zero_hit_w = (ZERO_REG != 0) && (waddr == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && !zero_hit_w) begin
      mem[waddr] <= wdata;
    end
  end

  // Masking on the read side keeps entry 0 at 0 even for a SWAP, since
  // the value routed into the partner entry comes from these ports.
  assign rdata_a = ((ZERO_REG != 0) && (raddr_a == '0)) ? '0 : mem[raddr_a];
  assign rdata_b = ((ZERO_REG != 0) && (raddr_b == '0)) ? '0 : mem[raddr_b];

endmodule

// File: rtl/mod_veda_rf.sv
// mod_veda_rf
//   Register file with one valid/ready request port: WRITE, dual READ,
//   COPY and (optionally) a two-cycle SWAP through an internal temp reg.
//   Mutating ops with write_enable = 0 are accepted, change nothing and
//   pulse err.
// Build macro: MOD_VEDA_RF_SWAP_EN -- when defined SWAP is implemented;
//   when undefined op 11 is illegal (one cycle, no change, err pulse).
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   write_enable      global gate for WRITE/COPY/SWAP
//   req_valid/ready   request handshake
//   op, addr_a, addr_b, datain   request fields
//   dout_a, dout_b    registered read data, held until next READ
//   rd_valid          one-cycle pulse on READ completion
//   err               one-cycle pulse on rejected request
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request
// SWAP2 | second half of a swap: temp written to latched addr_b
module mod_veda_rf
  import mod_veda_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dout_a,
  output logic [DATA_W-1:0] dout_b,
  output logic              rd_valid,
  output logic              err
);

  logic              accept;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              rd_nxt;
  logic              err_nxt;

`ifdef MOD_VEDA_RF_SWAP_EN
  state_t            state;
  state_t            state_nxt;
  logic              temp_ld;
  logic [DATA_W-1:0] temp;
  logic [ADDR_W-1:0] addr_b_lat;

  assign req_ready = rst && (state == IDLE);
`else
  assign req_ready = rst;
`endif

  assign accept = req_valid && req_ready;

  mod_veda_rf_bank #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (bank_we),
    .waddr   (bank_waddr),
    .wdata   (bank_wdata),
    .raddr_a (addr_a),
    .raddr_b (addr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = addr_a;
    bank_wdata = datain;
    rd_nxt     = 1'b0;
    err_nxt    = 1'b0;
`ifdef MOD_VEDA_RF_SWAP_EN
    state_nxt  = state;
    temp_ld    = 1'b0;
    if (state == SWAP2) begin
      bank_we    = 1'b1;
      bank_waddr = addr_b_lat;
      bank_wdata = temp;
      state_nxt  = IDLE;
    end else
`endif
    if (accept) begin
      case (op)
        OP_WRITE: begin
          if (write_enable) bank_we = 1'b1;
          else              err_nxt = 1'b1;
        end
        OP_READ: rd_nxt = 1'b1;
        OP_COPY: begin
          if (write_enable) begin
            bank_we    = 1'b1;
            bank_waddr = addr_b;
            bank_wdata = rdata_a;
          end else begin
            err_nxt = 1'b1;
          end
        end
        OP_SWAP: begin
`ifdef MOD_VEDA_RF_SWAP_EN
          if (write_enable) begin
            bank_we    = 1'b1;
            bank_waddr = addr_a;
            bank_wdata = rdata_b;
            temp_ld    = 1'b1;
            state_nxt  = SWAP2;
          end else begin
            err_nxt = 1'b1;
          end
`else
          err_nxt = 1'b1;
`endif
        end
      endcase
    end
  end

`ifdef MOD_VEDA_RF_SWAP_EN
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      temp       <= '0;
      addr_b_lat <= '0;
    end else if (temp_ld) begin
      temp       <= rdata_a;
      addr_b_lat <= addr_b;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_a   <= '0;
      dout_b   <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_nxt;
      err      <= err_nxt;
      if (rd_nxt) begin
        dout_a <= rdata_a;
        dout_b <= rdata_b;
      end
    end
  end

endmodule
